// File: rtl/ws_epm1270_pkg.sv
// rtl/ws_epm1270_pkg.sv - shared types, constants and helpers for the EPM1270 LED demo
package ws_epm1270_pkg;

    typedef enum logic [1:0] {
        SCAN_UP   = 2'd0,
        SCAN_DOWN = 2'd1,
        COUNT     = 2'd2
    } state_t;

    localparam int LED_W         = 4;
    localparam int SCAN_MAX      = 3;
    localparam int COUNT_MAX     = 15;
    localparam int HW_EXTRA_BITS = 16;

    // Simulation builds use the base width; hardware adds bits for a human-visible rate
    function automatic int prescale_width(input int c_size, input int sim);
        return (sim != 0) ? c_size : c_size + HW_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/ws_epm1270_prescaler.sv
// rtl/ws_epm1270_prescaler.sv - free-running counter producing a one-cycle tick every 2^W cycles
module ws_epm1270_prescaler #(
    parameter int W = 9
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [W-1:0] count;

    // Tick on the all-ones value; the increment then wraps naturally to zero
    assign tick = &count;

    // Free-running up-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ws_epm1270_led_top.sv
// rtl/ws_epm1270_led_top.sv - board top: reset sync, prescaler, scanner/counter FSM, active-low LED drive
module ws_epm1270_led_top
    import ws_epm1270_pkg::*;
#(
    parameter int C_SIZE = 9,
    parameter int SIM    = 0
) (
    input  logic             clk_50m,
    input  logic             rst,
    output logic [LED_W-1:0] led_n
);

    localparam int W = prescale_width(C_SIZE, SIM);

    logic [1:0] rst_sync;
    logic       rst_int;
    logic       tick;
    state_t     state;
    logic [1:0] pos;
    logic [3:0] cnt;

    // Assert immediately, release on the second clock edge after rst drops
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = ~rst_sync[1];

    ws_epm1270_prescaler #(
        .W(W)
    ) u_prescaler (
        .clk  (clk_50m),
        .rst  (rst_int),
        .tick (tick)
    );

    // Sequence FSM: bounce a single LED, then binary count; illegal states recover at once
    always_ff @(posedge clk_50m or posedge rst_int) begin
        if (rst_int) begin
            state <= SCAN_UP;
            pos   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                SCAN_UP: begin
                    if (tick) begin
                        if (pos < 2'(SCAN_MAX)) begin
                            pos <= pos + 2'd1;
                        end else begin
                            state <= SCAN_DOWN;
                            pos   <= 2'(SCAN_MAX - 1);
                        end
                    end
                end
                SCAN_DOWN: begin
                    if (tick) begin
                        if (pos > 2'd0) begin
                            pos <= pos - 2'd1;
                        end else begin
                            state <= COUNT;
                            cnt   <= 4'd0;
                        end
                    end
                end
                COUNT: begin
                    if (tick) begin
                        if (cnt < 4'(COUNT_MAX)) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            state <= SCAN_UP;
                            pos   <= 2'd0;
                            cnt   <= 4'd0;
                        end
                    end
                end
                default: begin
                    state <= SCAN_UP;
                    pos   <= 2'd0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Registered decode so the pins are glitch-free; LEDs are lit by driving 0
    always_ff @(posedge clk_50m or posedge rst_int) begin
        if (rst_int) begin
            led_n <= '1;
        end else begin
            case (state)
                SCAN_UP, SCAN_DOWN: led_n <= ~(4'b0001 << pos);
                COUNT:              led_n <= ~cnt;
                default:            led_n <= '1;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_epm1270_led_top.sv
// tb/tb_ws_epm1270_led_top.sv - directed self-checking bench for the EPM1270 LED demo top
module tb_ws_epm1270_led_top;

    localparam int TICK_CYC = 512;
    localparam int PERIOD   = 23 * TICK_CYC;
    localparam int BOUND    = 2000;

    logic       clk_50m;
    logic       rst;
    logic [3:0] led_n;

    int tests_run;
    int tests_failed;
    int x_seen;
    logic [3:0] exp_seq [23];

    ws_epm1270_led_top #(
        .C_SIZE(9),
        .SIM   (1)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .led_n   (led_n)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for led_n to change, sampling on falling edges
    task automatic wait_change(output int cycles, output logic [3:0] val);
        logic [3:0] prev;
        prev   = led_n;
        cycles = 0;
        do begin
            @(negedge clk_50m);
            cycles++;
            if ($isunknown(led_n)) x_seen++;
        end while (led_n === prev && cycles < BOUND);
        val = led_n;
    endtask

    task automatic step(input string tag, input logic [3:0] exp, inout int total);
        int c;
        logic [3:0] v;
        wait_change(c, v);
        check({tag, "_val"}, 32'(v), 32'(exp));
        check({tag, "_gap"}, c, TICK_CYC);
        total += c;
    endtask

    // Release rst between edges and verify the two-edge synchronised release
    task automatic release_and_check(input string tag);
        rst = 1'b0;
        @(negedge clk_50m);
        check({tag, "_e1"}, 32'(led_n), 32'hF);
        @(negedge clk_50m);
        check({tag, "_e2"}, 32'(led_n), 32'hF);
        @(negedge clk_50m);
        check({tag, "_e3"}, 32'(led_n), 32'hE);
    endtask

    initial begin
        int total;
        tests_run    = 0;
        tests_failed = 0;
        x_seen       = 0;

        exp_seq[0] = 4'b1101;
        exp_seq[1] = 4'b1011;
        exp_seq[2] = 4'b0111;
        exp_seq[3] = 4'b1011;
        exp_seq[4] = 4'b1101;
        exp_seq[5] = 4'b1110;
        for (int i = 0; i < 16; i++) exp_seq[6 + i] = ~4'(i);
        exp_seq[22] = 4'b1110;

        // Reset held for 5000 ns
        rst = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk_50m);
            if (i % 25 == 0) check("reset_hold", 32'(led_n), 32'hF);
        end
        release_and_check("release");

        // One full period: scanner, count, back to scan start
        total = 0;
        for (int i = 0; i < 23; i++) step($sformatf("p0_s%0d", i), exp_seq[i], total);
        check("p0_period", total, PERIOD);

        // Advance into COUNT up to cnt = 7
        total = 0;
        for (int i = 0; i < 14; i++) step($sformatf("pre_s%0d", i), exp_seq[i], total);
        check("mid_cnt7", 32'(led_n), 32'h8);

        // Asynchronous reset between clock edges
        repeat (100) @(negedge clk_50m);
        #5 rst = 1'b1;
        #1 check("mid_async", 32'(led_n), 32'hF);
        repeat (5) @(negedge clk_50m);
        check("mid_hold", 32'(led_n), 32'hF);
        release_and_check("restart");

        // Two further periods with no drift
        for (int p = 1; p <= 2; p++) begin
            total = 0;
            for (int i = 0; i < 23; i++) step($sformatf("p%0d_s%0d", p, i), exp_seq[i], total);
            check($sformatf("p%0d_period", p), total, PERIOD);
        end
        check("no_x", x_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
